bpu_update_arbiter: RTL and testbench
=====================================

// Module: bpu_update_arbiter
// PURPOSE
//  Collects BHT/BTB training requests from two branch units, buffers them in an in-order
//  FIFO and drains one per cycle into the single-ported BHT/BTB write interfaces.
//  Fetch-side reads have priority. Sits between the BJUs and the BPU arrays.
//  After reset, it sweeps the BTB to clear all valid bits before accepting updates.
// PARAMETERS
//  DEPTH      8    FIFO entries; power of 2, at least 4
//  SETS       512  BHT/BTB sets; also the INIT sweep length
//  IDX_W      9    set index width, log2(SETS)
// PORTS
//  clock          in   1    clock
//  reset          in   1    asynchronous reset, active-high
//  req0_valid     in   1    BJU0 training request
//  req0_index     in   IDX_W  set index, pc[12:4]
//  req0_sel       in   2    slot within set, pc[3:2]
//  req0_inc       in   1    increment the BHT counter (else decrement)
//  req0_btb_we    in   1    also write the BTB target
//  req0_target    in   32   BTB target
//  req1_*         in   -    same fields as req0_*, for BJU1
//  fetch_rd_busy  in   1    BPU arrays are being read this cycle; blocks the drain
//  flush          in   1    discard all queued entries
//  upd_ready      out  1    both request ports can be accepted this cycle
//  init_done      out  1    INIT sweep is complete
//  bht_write_enable, bht_valid_in          out 1      BHT write strobe, both the same value
//  bht_write_index                         out IDX_W  BHT set index
//  bht_write_counter_select                out 2      BHT counter slot
//  bht_write_inc, bht_write_dec            out 1      BHT counter direction
//  btb_ce, btb_we                          out 1      BTB write strobe, both the same value
//  btb_wmask, btb_din                      out 129    BTB write mask and data
//  btb_write_index                         out IDX_W  BTB set index
//  drop_cnt       out  16   saturating count of requests dropped
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; state INIT with sweep index 0.
//  - States: INIT -> RUN only. Reset from any state returns to INIT.
//  - INIT:
//    - Each cycle with fetch_rd_busy=0: btb_we=btb_ce=1, index=sweep, wmask=all ones, din=0; sweep+1.
//    - When fetch_rd_busy=1: no write, sweep holds.
//    - After writing index SETS-1: go to RUN; init_done=1 from the next cycle on.
//    - upd_ready=0 throughout INIT; requests arriving in INIT are dropped.
//  - upd_ready = (state==RUN) & (free entries >= 2). It is combinational from registered state.
//  - Enqueue when upd_ready=1:
//    - valid requests are pushed in order req0 then req1.
//    - both valid in the same cycle gives 2 pushes.
//  - Drop: each reqN_valid while upd_ready=0 adds 1 to drop_cnt. drop_cnt saturates at 16'hFFFF.
//  - Drain in RUN:
//    - when FIFO is non-empty and fetch_rd_busy=0, pop the head.
//    - The entry popped in cycle N appears on the registered write outputs in cycle N+1, asserted for exactly 1 cycle.
//  - BHT fields from the popped entry:
//    - enable = valid_in = 1; index and counter_select from the entry.
//    - inc = entry.inc; dec = ~entry.inc.
//  - BTB fields when entry.btb_we=1:
//    - ce = we = 1; write_index = entry index.
//    - wmask = {1'b1, 32-bit ones in slot sel, zeros in the other slots}. Slot s occupies bits [32s+31:32s].
//    - din = {1'b1, target placed in slot sel, 0 elsewhere}.
//    - When btb_we=0: BTB outputs are 0.
//  - Minimum latency from request to array write: 2 cycles (accept at N, pop at N+1, write outputs at N+2).
//  - Same-cycle push and pop are allowed; occupancy is updated by pushes minus pop.
//  - Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. full/empty come from the MSB compare.
//  - flush (RUN state):
//    - empties the FIFO that cycle; same-cycle pushes are discarded, not counted as drops.
//    - a write already on the outputs still completes.
//    - flush in INIT is ignored.
//  - No coalescing: two updates to the same index/sel are written in order as separate writes.
// TESTING
//  - Reset release, fetch_rd_busy=0 -> 512 BTB writes, index 0..511, wmask all ones, din 0; init_done high at cycle 513.
//  - INIT with fetch_rd_busy toggling 1/0 -> sweep pauses on busy; no index skipped or repeated.
//  - RUN: req0 {idx 5, sel 2, inc, btb_we, target 32'h8000_1000} ->
//    - 2 cycles later: bht index 5, select 2, inc=1;
//    - btb_wmask bits [95:64] and bit 128 set; din[95:64]=32'h8000_1000.
//  - req0 and req1 valid in the same cycle -> req0's write appears one cycle before req1's write.
//  - fetch_rd_busy held high, both ports valid every cycle -> upd_ready falls at 7 queued entries with DEPTH=8;
//    drop_cnt then counts 2 per cycle.
//  - 6 entries queued, then flush with req0 valid -> FIFO empty, drop_cnt unchanged, no further writes.

Source files
------------

// File: rtl/bpu_update_arbiter.sv
// bpu_update_arbiter: queues BHT/BTB training requests from two branch units and drains
// one per cycle into the single-ported BPU arrays, after an initial BTB valid-bit sweep.
//   clock, reset                 clock, asynchronous active-high reset
//   req0_*/req1_*                training requests (valid, index, sel, inc, btb_we, target)
//   fetch_rd_busy                fetch is reading the arrays; blocks sweep and drain
//   flush                        discard all queued entries (RUN only)
//   upd_ready                    both request ports can be accepted this cycle
//   init_done                    BTB sweep complete
//   bht_*                        registered BHT write port
//   btb_*                        registered BTB write port
//   drop_cnt                     saturating count of dropped requests
module bpu_update_arbiter #(
    parameter int DEPTH = 8,
    parameter int SETS  = 512,
    parameter int IDX_W = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [IDX_W-1:0] req0_index,
    input  logic [1:0]       req0_sel,
    input  logic             req0_inc,
    input  logic             req0_btb_we,
    input  logic [31:0]      req0_target,
    input  logic             req1_valid,
    input  logic [IDX_W-1:0] req1_index,
    input  logic [1:0]       req1_sel,
    input  logic             req1_inc,
    input  logic             req1_btb_we,
    input  logic [31:0]      req1_target,
    input  logic             fetch_rd_busy,
    input  logic             flush,
    output logic             upd_ready,
    output logic             init_done,
    output logic             bht_write_enable,
    output logic             bht_valid_in,
    output logic [IDX_W-1:0] bht_write_index,
    output logic [1:0]       bht_write_counter_select,
    output logic             bht_write_inc,
    output logic             bht_write_dec,
    output logic             btb_ce,
    output logic             btb_we,
    output logic [128:0]     btb_wmask,
    output logic [128:0]     btb_din,
    output logic [IDX_W-1:0] btb_write_index,
    output logic [15:0]      drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       sel;
        logic             inc;
        logic             bwe;
        logic [31:0]      tgt;
    } entry_t;

    state_t           state;
    entry_t           mem [DEPTH];
    entry_t           e0, e1, head;
    logic [AW:0]      wr_ptr, rd_ptr, count, wr1;
    logic [IDX_W-1:0] sweep;
    logic             run, empty, push0, push1, pop, btb_w;
    logic [127:0]     slot_mask, slot_data;
    logic [16:0]      drop_sum;

    assign e0        = {req0_index, req0_sel, req0_inc, req0_btb_we, req0_target};
    assign e1        = {req1_index, req1_sel, req1_inc, req1_btb_we, req1_target};
    assign run       = state == RUN;
    assign count     = wr_ptr - rd_ptr;
    assign empty     = wr_ptr == rd_ptr;
    assign upd_ready = run && count <= (AW+1)'(DEPTH - 2);
    // pushes that coincide with a flush are thrown away, so they never touch the FIFO
    assign push0     = upd_ready & ~flush & req0_valid;
    assign push1     = upd_ready & ~flush & req1_valid;
    // req1 lands behind req0 when both are pushed together
    assign wr1       = wr_ptr + (AW+1)'(push0);
    assign pop       = run & ~empty & ~fetch_rd_busy & ~flush;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign slot_mask = {96'd0, 32'hFFFF_FFFF} << {head.sel, 5'd0};
    assign slot_data = {96'd0, head.tgt} << {head.sel, 5'd0};
    // INIT owns the BTB port for the sweep; RUN writes it only for entries carrying a target
    assign btb_w     = run ? pop & head.bwe : ~fetch_rd_busy;
    assign drop_sum  = {1'b0, drop_cnt} + 17'(req0_valid & ~upd_ready) + 17'(req1_valid & ~upd_ready);

    always_ff @(posedge clock) begin
        if (push0) mem[wr_ptr[AW-1:0]] <= e0;
        if (push1) mem[wr1[AW-1:0]] <= e1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                    <= INIT;
            sweep                    <= '0;
            wr_ptr                   <= '0;
            rd_ptr                   <= '0;
            init_done                <= 1'b0;
            bht_write_enable         <= 1'b0;
            bht_valid_in             <= 1'b0;
            bht_write_index          <= '0;
            bht_write_counter_select <= '0;
            bht_write_inc            <= 1'b0;
            bht_write_dec            <= 1'b0;
            btb_ce                   <= 1'b0;
            btb_we                   <= 1'b0;
            btb_wmask                <= '0;
            btb_din                  <= '0;
            btb_write_index          <= '0;
            drop_cnt                 <= '0;
        end else begin
            wr_ptr                   <= wr_ptr + (AW+1)'(push0) + (AW+1)'(push1);
            rd_ptr                   <= (run & flush) ? wr_ptr : rd_ptr + (AW+1)'(pop);
            init_done                <= run;
            bht_write_enable         <= pop;
            bht_valid_in             <= pop;
            bht_write_index          <= pop ? head.idx : '0;
            bht_write_counter_select <= pop ? head.sel : '0;
            bht_write_inc            <= pop & head.inc;
            bht_write_dec            <= pop & ~head.inc;
            btb_ce                   <= btb_w;
            btb_we                   <= btb_w;
            btb_write_index          <= btb_w ? (run ? head.idx : sweep) : '0;
            btb_wmask                <= btb_w ? (run ? {1'b1, slot_mask} : '1) : '0;
            btb_din                  <= (btb_w & run) ? {1'b1, slot_data} : '0;
            drop_cnt                 <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (!run && !fetch_rd_busy) begin
                sweep <= sweep + IDX_W'(1);
                if (sweep == IDX_W'(SETS - 1)) state <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_bpu_update_arbiter.sv
// tb_bpu_update_arbiter: directed self-checking bench for bpu_update_arbiter.
module tb_bpu_update_arbiter;
    logic         clock = 0, reset = 1;
    logic         req0_valid = 0, req0_inc = 0, req0_btb_we = 0;
    logic [8:0]   req0_index = 0;
    logic [1:0]   req0_sel = 0;
    logic [31:0]  req0_target = 0;
    logic         req1_valid = 0, req1_inc = 0, req1_btb_we = 0;
    logic [8:0]   req1_index = 0;
    logic [1:0]   req1_sel = 0;
    logic [31:0]  req1_target = 0;
    logic         fetch_rd_busy = 0, flush = 0;
    logic         upd_ready, init_done, bht_write_enable, bht_valid_in;
    logic [8:0]   bht_write_index, btb_write_index;
    logic [1:0]   bht_write_counter_select;
    logic         bht_write_inc, bht_write_dec, btb_ce, btb_we;
    logic [128:0] btb_wmask, btb_din;
    logic [15:0]  drop_cnt;
    int           n_cmp = 0, n_err = 0, exp_idx, writes;

    bpu_update_arbiter dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_index(req0_index), .req0_sel(req0_sel),
        .req0_inc(req0_inc), .req0_btb_we(req0_btb_we), .req0_target(req0_target),
        .req1_valid(req1_valid), .req1_index(req1_index), .req1_sel(req1_sel),
        .req1_inc(req1_inc), .req1_btb_we(req1_btb_we), .req1_target(req1_target),
        .fetch_rd_busy(fetch_rd_busy), .flush(flush),
        .upd_ready(upd_ready), .init_done(init_done),
        .bht_write_enable(bht_write_enable), .bht_valid_in(bht_valid_in),
        .bht_write_index(bht_write_index), .bht_write_counter_select(bht_write_counter_select),
        .bht_write_inc(bht_write_inc), .bht_write_dec(bht_write_dec),
        .btb_ce(btb_ce), .btb_we(btb_we), .btb_wmask(btb_wmask), .btb_din(btb_din),
        .btb_write_index(btb_write_index), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_req();
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic set_req0(input logic [8:0] idx, input logic [1:0] sel, input logic inc,
                            input logic bwe, input logic [31:0] tgt);
        req0_valid = 1; req0_index = idx; req0_sel = sel; req0_inc = inc;
        req0_btb_we = bwe; req0_target = tgt;
    endtask

    task automatic set_req1(input logic [8:0] idx, input logic [1:0] sel, input logic inc,
                            input logic bwe, input logic [31:0] tgt);
        req1_valid = 1; req1_index = idx; req1_sel = sel; req1_inc = inc;
        req1_btb_we = bwe; req1_target = tgt;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    initial begin
        step();
        step();
        check("rst_ready", upd_ready, 0);
        check("rst_init_done", init_done, 0);
        check("rst_bht_en", bht_write_enable, 0);
        check("rst_btb_we", btb_we, 0);
        check("rst_btb_wmask", btb_wmask, 0);
        check("rst_drop", drop_cnt, 0);
        reset = 0;

        // full sweep with no fetch traffic
        for (int k = 0; k < 512; k++) begin
            step();
            check("sweep_we", {btb_we, btb_ce}, 2'b11);
            check("sweep_idx", btb_write_index, k);
            check("sweep_mask", btb_wmask, {129{1'b1}});
            check("sweep_din", btb_din, 0);
            check("sweep_ready", upd_ready, (k == 511) ? 1 : 0);
        end
        check("sweep_done_early", init_done, 0);
        step();
        check("sweep_done", init_done, 1);
        check("sweep_stop", btb_we, 0);

        // sweep paused by alternating fetch reads, plus requests dropped during INIT
        do_reset();
        exp_idx = 0;
        for (int i = 0; i < 1100 && exp_idx < 512; i++) begin
            fetch_rd_busy = i[0];
            req0_valid = (i < 3);
            step();
            if (!fetch_rd_busy) begin
                check("busy_sweep_idx", btb_write_index, exp_idx);
                check("busy_sweep_we", btb_we, 1);
                exp_idx++;
            end else begin
                check("busy_sweep_hold", btb_we, 0);
            end
        end
        check("busy_sweep_count", exp_idx, 512);
        fetch_rd_busy = 0;
        clr_req();
        step();
        check("busy_sweep_done", init_done, 1);
        check("init_drops", drop_cnt, 3);

        // single request: written two cycles after acceptance
        set_req0(5, 2, 1, 1, 32'h8000_1000);
        check("single_ready", upd_ready, 1);
        step();
        clr_req();
        check("single_not_yet", bht_write_enable, 0);
        step();
        check("single_bht", {bht_write_enable, bht_valid_in, bht_write_index, bht_write_counter_select,
                             bht_write_inc, bht_write_dec}, {1'b1, 1'b1, 9'd5, 2'd2, 1'b1, 1'b0});
        check("single_btb", {btb_ce, btb_we, btb_write_index}, {1'b1, 1'b1, 9'd5});
        check("single_wmask", btb_wmask, 129'h1_00000000_FFFFFFFF_00000000_00000000);
        check("single_din", btb_din, 129'h1_00000000_80001000_00000000_00000000);
        step();
        check("single_one_cycle", {bht_write_enable, btb_we}, 0);

        // both ports together: req0 written first
        set_req0(10, 0, 0, 0, 32'h1234_5678);
        set_req1(20, 3, 1, 1, 32'hDEAD_BEEF);
        step();
        clr_req();
        step();
        check("pair0_bht", {bht_write_enable, bht_write_index, bht_write_counter_select,
                            bht_write_inc, bht_write_dec}, {1'b1, 9'd10, 2'd0, 1'b0, 1'b1});
        check("pair0_btb_off", {btb_ce, btb_we, btb_write_index}, 0);
        check("pair0_mask_off", btb_wmask, 0);
        check("pair0_din_off", btb_din, 0);
        step();
        check("pair1_bht", {bht_write_enable, bht_write_index, bht_write_counter_select,
                            bht_write_inc, bht_write_dec}, {1'b1, 9'd20, 2'd3, 1'b1, 1'b0});
        check("pair1_wmask", btb_wmask, 129'h1_FFFFFFFF_00000000_00000000_00000000);
        check("pair1_din", btb_din, 129'h1_DEADBEEF_00000000_00000000_00000000);
        step();
        check("pair_idle", bht_write_enable, 0);

        // fill while fetch blocks the drain: 1, 3, 5, 7 entries
        fetch_rd_busy = 1;
        set_req0(1, 0, 1, 0, 0);
        step();
        clr_req();
        check("fill1_ready", upd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            set_req0(9'(2 + 2 * i), 1, 1, 0, 0);
            set_req1(9'(3 + 2 * i), 1, 0, 0, 0);
            step();
            check("fill_ready", upd_ready, (i == 2) ? 0 : 1);
            check("fill_no_write", bht_write_enable, 0);
        end
        step();
        check("fill_drop2", drop_cnt, 5);
        step();
        check("fill_drop4", drop_cnt, 7);
        clr_req();
        fetch_rd_busy = 0;
        exp_idx = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bht_write_enable) begin
                check("drain_order", bht_write_index, exp_idx);
                exp_idx++;
            end
        end
        check("drain_count", exp_idx, 8);

        // six queued, then flush with req0 valid
        fetch_rd_busy = 1;
        for (int i = 0; i < 3; i++) begin
            set_req0(30, 0, 1, 0, 0);
            set_req1(31, 0, 1, 0, 0);
            step();
        end
        check("pre_flush_ready", upd_ready, 1);
        clr_req();
        set_req0(40, 0, 1, 0, 0);
        flush = 1;
        step();
        flush = 0;
        clr_req();
        fetch_rd_busy = 0;
        check("flush_drop", drop_cnt, 7);
        writes = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            writes += int'(bht_write_enable);
        end
        check("flush_no_writes", writes, 0);
        set_req0(7, 1, 0, 1, 32'h0000_00AA);
        step();
        clr_req();
        step();
        check("post_flush_idx", {bht_write_enable, bht_write_index}, {1'b1, 9'd7});
        check("post_flush_din", btb_din, 129'h1_00000000_00000000_000000AA_00000000);

        // drop counter saturation with the FIFO held full
        fetch_rd_busy = 1;
        set_req0(0, 0, 0, 0, 0);
        set_req1(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step();
        check("full_ready", upd_ready, 0);
        for (int i = 0; i < 32800; i++) step();
        check("drop_sat", drop_cnt, 16'hFFFF);
        step();
        check("drop_sat_hold", drop_cnt, 16'hFFFF);
        clr_req();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
